// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer: FSM states,
// control character codes and default screen geometry.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SET_ZERO,
    CLR_LINE,
    CLR_ALL
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam int DEF_COLS   = 70;
  localparam int DEF_ROWS   = 30;
  localparam int DEF_STRIDE = 128;
  localparam int DEF_BASE   = 4;

  localparam int ADDR_W = 20;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/console_addr.sv
// Maps a logical (row, col) plus the scroll offset onto a video memory
// address; the ring wrap is a single compare-and-subtract.
module console_addr
  import console_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int STRIDE = DEF_STRIDE,
  parameter int BASE   = DEF_BASE
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [ROW_W-1:0]  zero,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ROW_W:0] ROWS_W = (ROW_W + 1)'(ROWS);

  logic [ROW_W:0]   sum;
  logic [ROW_W:0]   wrapped;
  logic [ROW_W-1:0] prow;

  // Both operands are below ROWS, so one subtraction is enough to wrap.
  always_comb begin
    sum     = {1'b0, row} + {1'b0, zero};
    wrapped = (sum >= ROWS_W) ? (sum - ROWS_W) : sum;
    prow    = wrapped[ROW_W-1:0];
    addr    = ADDR_W'(BASE) + ADDR_W'(prow) * ADDR_W'(STRIDE) + ADDR_W'(col);
  end

endmodule

// File: rtl/vmem_console_writer.sv
// Character stream to text video memory writer: cursor tracking, control
// codes, hardware scrolling through the scroll register and screen clear.
module vmem_console_writer
  import console_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int STRIDE = DEF_STRIDE,
  parameter int BASE   = DEF_BASE
) (
  input  logic              wrclk,
  input  logic              rst,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] wraddr,
  output logic [7:0]        datain,
  output logic              we,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROWS_R   = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  zero_q, zero_d;
  logic [ROW_W-1:0]  cnt_row_q, cnt_row_d;
  logic [COL_W-1:0]  cnt_col_q, cnt_col_d;
  logic              pre_q, pre_d;
  logic              scroll_q, scroll_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic [ROW_W-1:0]  zero_inc;
  logic [ROW_W-1:0]  all_row;
  logic [COL_W-1:0]  bs_col, line_col, all_col;
  logic [ADDR_W-1:0] cur_addr, bs_addr, line_addr, all_addr;
  logic              accept;

  assign accept   = char_valid && ready_q;
  assign zero_inc = (zero_q == LAST_ROW) ? '0 : zero_q + 1'b1;
  assign bs_col   = col_q - 1'b1;
  assign line_col = (state_q == CLR_LINE) ? cnt_col_q + 1'b1 : '0;

  // pre_q marks a clear that has not yet issued its first cell.
  assign all_col = (pre_q || cnt_col_q == LAST_COL) ? '0 : cnt_col_q + 1'b1;
  assign all_row = pre_q ? '0 :
                   (cnt_col_q == LAST_COL) ? cnt_row_q + 1'b1 : cnt_row_q;

  console_addr #(.ROWS(ROWS), .STRIDE(STRIDE), .BASE(BASE)) u_cur (
    .row(row_q), .zero(zero_q), .col(col_q), .addr(cur_addr)
  );

  console_addr #(.ROWS(ROWS), .STRIDE(STRIDE), .BASE(BASE)) u_bs (
    .row(row_q), .zero(zero_q), .col(bs_col), .addr(bs_addr)
  );

  // The line scrolled in is the bottom logical row under the new offset.
  console_addr #(.ROWS(ROWS), .STRIDE(STRIDE), .BASE(BASE)) u_line (
    .row(LAST_ROW), .zero(zero_q), .col(line_col), .addr(line_addr)
  );

  console_addr #(.ROWS(ROWS), .STRIDE(STRIDE), .BASE(BASE)) u_all (
    .row(all_row), .zero('0), .col(all_col), .addr(all_addr)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    zero_d    = zero_q;
    cnt_row_d = cnt_row_q;
    cnt_col_d = cnt_col_q;
    pre_d     = pre_q;
    scroll_d  = scroll_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_printable(char_in)) begin
            we_d    = 1'b1;
            addr_d  = cur_addr;
            data_d  = char_in;
            state_d = PUT;
            if (col_q == LAST_COL) begin
              col_d = '0;
              if (row_q != LAST_ROW) row_d = row_q + 1'b1;
              else                   scroll_d = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            unique case (char_in)
              CH_LF: begin
                col_d = '0;
                if (row_q != LAST_ROW) begin
                  row_d   = row_q + 1'b1;
                  state_d = PUT;
                end else begin
                  we_d    = 1'b1;
                  addr_d  = '0;
                  data_d  = 8'(zero_inc);
                  zero_d  = zero_inc;
                  state_d = SET_ZERO;
                end
              end
              CH_CR: col_d = '0;
              CH_BS: begin
                if (col_q != '0) begin
                  col_d   = bs_col;
                  we_d    = 1'b1;
                  addr_d  = bs_addr;
                  data_d  = CH_SPACE;
                  state_d = PUT;
                end
              end
              CH_FF: begin
                pre_d   = 1'b1;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      PUT: begin
        if (scroll_q) begin
          scroll_d = 1'b0;
          we_d     = 1'b1;
          addr_d   = '0;
          data_d   = 8'(zero_inc);
          zero_d   = zero_inc;
          state_d  = SET_ZERO;
        end else begin
          state_d = IDLE;
        end
      end

      SET_ZERO: begin
        cnt_col_d = '0;
        we_d      = 1'b1;
        addr_d    = line_addr;
        data_d    = CH_SPACE;
        state_d   = CLR_LINE;
      end

      CLR_LINE: begin
        if (cnt_col_q == LAST_COL) begin
          state_d = IDLE;
        end else begin
          cnt_col_d = line_col;
          we_d      = 1'b1;
          addr_d    = line_addr;
          data_d    = CH_SPACE;
        end
      end

      CLR_ALL: begin
        if (!pre_q && cnt_row_q == ROWS_R) begin
          state_d = IDLE;
        end else begin
          pre_d     = 1'b0;
          cnt_row_d = all_row;
          cnt_col_d = all_col;
          we_d      = 1'b1;
          // Row counter reaching ROWS means every cell is blank: reset the scroll register.
          if (all_row == ROWS_R) begin
            addr_d = '0;
            data_d = 8'h00;
            zero_d = '0;
            row_d  = '0;
            col_d  = '0;
          end else begin
            addr_d = all_addr;
            data_d = CH_SPACE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge wrclk) begin
    if (rst) begin
      state_q   <= CLR_ALL;
      pre_q     <= 1'b1;
      scroll_q  <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      zero_q    <= '0;
      cnt_row_q <= '0;
      cnt_col_q <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      scroll_q  <= scroll_d;
      row_q     <= row_d;
      col_q     <= col_d;
      zero_q    <= zero_d;
      cnt_row_q <= cnt_row_d;
      cnt_col_q <= cnt_col_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign char_ready = ready_q;
  assign we         = we_q;
  assign wraddr     = addr_q;
  assign datain     = data_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;

endmodule

// File: tb/tb_vmem_console_writer.sv
// Scoreboard bench for vmem_console_writer: expected writes are queued with
// the stimulus and a negedge monitor pops them as the DUT strobes we.
module tb_vmem_console_writer;

  logic        wrclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [19:0] wraddr;
  logic [7:0]  datain;
  logic        we;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  int checks = 0;
  int failures = 0;
  logic [27:0] sb[$];

  vmem_console_writer dut (
    .wrclk(wrclk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wraddr(wraddr), .datain(datain), .we(we),
    .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 wrclk = ~wrclk;

  function automatic logic [19:0] ea(input int lrow, input int z, input int c);
    return 20'(4 + ((lrow + z) % 30) * 128 + c);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [19:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  task automatic push_clr_all();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 70; c++) push(20'(4 + r * 128 + c), 8'h20);
    push(20'd0, 8'h00);
  endtask

  task automatic push_scroll(input int z);
    push(20'd0, 8'(z));
    for (int c = 0; c < 70; c++) push(ea(29, z, c), 8'h20);
  endtask

  task automatic wait_ready(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    while (char_ready !== 1'b1 && lat < 3000) begin
      @(posedge wrclk); #1;
      lat++;
    end
    chk(nm, lat, exp_lat);
  endtask

  task automatic send(input logic [7:0] c, input int exp_lat);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < 3000) begin
      @(posedge wrclk); #1;
      n++;
    end
    chk("ready_before_send", int'(char_ready === 1'b1), 1);
    char_in = c;
    char_valid = 1'b1;
    @(posedge wrclk); #1;
    char_valid = 1'b0;
    wait_ready("turnaround", exp_lat);
  endtask

  task automatic chk_cursor(input string nm, input int r, input int c);
    chk({nm, "_row"}, int'(cur_row), r);
    chk({nm, "_col"}, int'(cur_col), c);
  endtask

  always @(negedge wrclk) begin
    if (we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", wraddr, datain);
      end else begin
        logic [27:0] e;
        e = sb.pop_front();
        if ({wraddr, datain} !== e) begin
          failures++;
          $display("FAIL write actual addr=%0d data=%h expected addr=%0d data=%h",
                   wraddr, datain, e[27:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge wrclk);
    #1;
    chk("rst_we", int'(we), 0);
    chk("rst_wraddr", int'(wraddr), 0);
    chk("rst_datain", int'(datain), 0);
    chk("rst_ready", int'(char_ready), 0);
    chk_cursor("rst_cursor", 0, 0);
    push_clr_all();
    rst = 1'b0;
    wait_ready("reset_clear_latency", 2102);
    chk("reset_clear_drained", sb.size(), 0);
    chk_cursor("after_clear", 0, 0);

    // single printable
    push(20'd4, 8'h41);
    send(8'h41, 1);
    chk_cursor("after_A", 0, 1);

    // CR and ignored code: no write, immediate ready
    send(8'h0D, 0);
    chk_cursor("after_cr", 0, 0);
    send(8'h01, 0);
    chk_cursor("after_ignored", 0, 0);

    // 71 chars wrap into row 1
    for (int c = 0; c < 70; c++) push(20'(4 + c), 8'h78);
    push(20'd132, 8'h78);
    for (int i = 0; i < 71; i++) send(8'h78, 1);
    chk_cursor("after_wrap", 1, 1);

    // backspace, then backspace at column 0
    push(20'd132, 8'h20);
    send(8'h08, 1);
    chk_cursor("after_bs", 1, 0);
    send(8'h08, 0);
    chk_cursor("after_bs_col0", 1, 0);

    // walk down to the bottom line, put 5 chars
    for (int i = 0; i < 28; i++) send(8'h0A, 1);
    chk_cursor("at_bottom", 29, 0);
    for (int c = 0; c < 5; c++) push(20'(3716 + c), 8'h78);
    for (int i = 0; i < 5; i++) send(8'h78, 1);
    chk_cursor("bottom_5", 29, 5);

    // two newline scrolls
    push_scroll(1);
    send(8'h0A, 71);
    chk_cursor("scroll1", 29, 0);
    push_scroll(2);
    send(8'h0A, 71);
    chk_cursor("scroll2", 29, 0);

    // wrap on the bottom line scrolls after the PUT
    for (int c = 0; c < 70; c++) push(ea(29, 2, c), 8'h79);
    push_scroll(3);
    for (int i = 0; i < 69; i++) send(8'h79, 1);
    send(8'h79, 72);
    chk_cursor("wrap_scroll", 29, 0);

    // scroll up to zero = 28, then backspace across the ring wrap
    for (int z = 4; z <= 28; z++) begin
      push_scroll(z);
      send(8'h0A, 71);
    end
    for (int c = 0; c < 10; c++) push(ea(29, 28, c), 8'h7A);
    for (int i = 0; i < 10; i++) send(8'h7A, 1);
    chk_cursor("z28_put", 29, 10);
    push(20'd3469, 8'h20);
    send(8'h08, 1);
    chk_cursor("z28_bs", 29, 9);

    // form feed
    push_clr_all();
    send(8'h0C, 2102);
    chk("ff_drained", sb.size(), 0);
    chk_cursor("after_ff", 0, 0);
    push(20'd4, 8'h41);
    send(8'h41, 1);

    // reset during CLR_LINE
    for (int i = 0; i < 29; i++) send(8'h0A, 1);
    chk_cursor("pre_rst_bottom", 29, 0);
    push_scroll(1);
    char_in = 8'h0A;
    char_valid = 1'b1;
    @(posedge wrclk); #1;
    char_valid = 1'b0;
    @(posedge wrclk); #1;
    rst = 1'b1;
    @(posedge wrclk); #1;
    chk("midrst_we", int'(we), 0);
    chk("midrst_wraddr", int'(wraddr), 0);
    chk("midrst_ready", int'(char_ready), 0);
    chk("midrst_popped", sb.size(), 69);
    sb.delete();
    push_clr_all();
    @(posedge wrclk); #1;
    rst = 1'b0;
    wait_ready("rerun_clear_latency", 2102);
    chk("rerun_drained", sb.size(), 0);
    chk_cursor("after_rerun", 0, 0);
    push(20'd4, 8'h42);
    send(8'h42, 1);
    chk("final_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
